// File: rtl/port_in_fifo.sv
// Input-port FIFO: buffers producer bytes behind a valid/ready handshake and
// shows the head word to the datapath until the control unit pops it.
module port_in_fifo #(
    parameter int data_size = 8,
    parameter int depth     = 4,
    parameter int ptr_size  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [data_size-1:0] in_data,
    output logic                 in_ready,
    input  logic                 rd_en,
    output logic [data_size-1:0] port_data,
    output logic                 port_avail,
    output logic [ptr_size:0]    count,
    output logic                 underflow,
    input  logic                 clr_err
);

    localparam logic [ptr_size-1:0] PtrOne   = 1;
    localparam logic [ptr_size:0]   CntOne   = 1;
    localparam logic [ptr_size:0]   CntDepth = (ptr_size+1)'(depth);

    logic [data_size-1:0] mem_q [depth];
    logic [ptr_size-1:0]  wp_q, wp_d;
    logic [ptr_size-1:0]  rp_q, rp_d;
    logic [ptr_size:0]    count_q, count_d;
    logic                 underflow_q, underflow_d;
    logic                 push, pop;

    // Full is judged from the registered count only, so a pop never frees a slot
    // for a push in the same cycle.
    assign in_ready   = (count_q != CntDepth);
    assign port_avail = (count_q != '0);
    assign port_data  = port_avail ? mem_q[rp_q] : '0;
    assign count      = count_q;
    assign underflow  = underflow_q;

    assign push = in_valid && in_ready;
    assign pop  = rd_en && port_avail;

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        if (push) begin
            wp_d = wp_q + PtrOne;
        end
        if (pop) begin
            rp_d = rp_q + PtrOne;
        end
        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (pop && !push) begin
            count_d = count_q - CntOne;
        end
        // A fresh underflow beats a simultaneous clear.
        if (rd_en && !port_avail) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; the pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wp_q] <= in_data;
        end
    end

endmodule
